// File: rtl/multicycle_control_fsm.sv
// Multicycle control sequencer: walks each instruction through fetch/decode/execute/memory/writeback.
// States: 0 idle | 1 fetch | 2 decode | 3 memadr | 4 memrd | 5 memwb | 6 memwr | 7 exec | 8 aluwb | 9 branch | 10 jump | 11 jal | 12 mdu | 13 trap
module multicycle_control_fsm #(
  parameter int OPC_W       = 6,
  parameter int ALUOP_W     = 6,
  parameter int ALU_ADD     = 3,
  parameter int MDU_LAT     = 4,
  parameter int MEM_WAIT_EN = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [OPC_W-1:0]   opcode,
  input  logic               mem_ready,
  output logic               PCWrite,
  output logic               PCWriteCond,
  output logic               IorD,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic               MemtoReg,
  output logic               RegDst,
  output logic               RegWrite,
  output logic               ALUSrcA,
  output logic               LinkSel,
  output logic               mdu_start,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         PCSource,
  output logic [ALUOP_W-1:0] ALUOp,
  output logic               illegal_op,
  output logic [3:0]         state
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_EXEC   = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9,
    S_JUMP   = 4'd10,
    S_JAL    = 4'd11,
    S_MDU    = 4'd12,
    S_TRAP   = 4'd13
  } state_t;

  typedef struct packed {
    logic               pc_write;
    logic               pc_write_cond;
    logic               iord;
    logic               mem_read;
    logic               mem_write;
    logic               mem_to_reg;
    logic               reg_dst;
    logic               reg_write;
    logic               alu_src_a;
    logic               link_sel;
    logic               mdu_start;
    logic [1:0]         alu_src_b;
    logic [1:0]         pc_source;
    logic [ALUOP_W-1:0] alu_op;
  } ctrl_t;

  localparam int CNT_W = (MDU_LAT > 0) ? $clog2(MDU_LAT + 1) : 1;

  localparam logic [OPC_W-1:0] OP_RTYPE  = OPC_W'(0);
  localparam logic [OPC_W-1:0] OP_ADDI   = OPC_W'(1);
  localparam logic [OPC_W-1:0] OP_LW     = OPC_W'(4);
  localparam logic [OPC_W-1:0] OP_SW     = OPC_W'(5);
  localparam logic [OPC_W-1:0] OP_BR6    = OPC_W'(6);
  localparam logic [OPC_W-1:0] OP_SRA    = OPC_W'(7);
  localparam logic [OPC_W-1:0] OP_BR_LO  = OPC_W'(8);
  localparam logic [OPC_W-1:0] OP_BR_HI  = OPC_W'(13);
  localparam logic [OPC_W-1:0] OP_JUMP   = OPC_W'(14);
  localparam logic [OPC_W-1:0] OP_IMUL   = OPC_W'(15);
  localparam logic [OPC_W-1:0] OP_DIVI   = OPC_W'(16);
  localparam logic [OPC_W-1:0] OP_JAL    = OPC_W'(17);
  localparam logic [OPC_W-1:0] OP_ALU18  = OPC_W'(18);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  ctrl_t            ctrl_q;
  logic             illegal_q;
  logic             mem_ok;
  logic             fetch_adv;
  logic             is_mdu;

  assign mem_ok = (MEM_WAIT_EN != 0) ? mem_ready : 1'b1;
  assign is_mdu = (opcode == OP_IMUL) || (opcode == OP_DIVI);

  function automatic state_t decode_target(input logic [OPC_W-1:0] opc);
    if (opc == OP_RTYPE || opc == OP_ADDI || opc == OP_SRA ||
        opc == OP_IMUL  || opc == OP_DIVI || opc == OP_ALU18)
      return S_EXEC;
    if (opc == OP_LW || opc == OP_SW)
      return S_MEMADR;
    if (opc == OP_BR6 || (opc >= OP_BR_LO && opc <= OP_BR_HI))
      return S_BRANCH;
    if (opc == OP_JUMP)
      return S_JUMP;
    if (opc == OP_JAL)
      return S_JAL;
    return S_TRAP;
  endfunction

  function automatic logic [ALUOP_W-1:0] exec_aluop(input logic [OPC_W-1:0] opc);
    if (opc == OP_ADDI || opc == OP_SRA)  return ALUOP_W'(2);
    if (opc == OP_IMUL || opc == OP_DIVI) return ALUOP_W'(15);
    if (opc == OP_ALU18)                  return ALUOP_W'(17);
    return ALUOP_W'(0);
  endfunction

  // Control word for the state being entered; latched alongside the state register.
  function automatic ctrl_t decode_ctrl(input state_t s, input logic [OPC_W-1:0] opc);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.mem_read  = 1'b1;
        c.alu_src_b = 2'b01;
        c.alu_op    = ALUOP_W'(ALU_ADD);
      end
      S_DECODE: begin
        c.alu_src_b = 2'b11;
        c.alu_op    = ALUOP_W'(ALU_ADD);
      end
      S_MEMADR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
        c.alu_op    = ALUOP_W'(ALU_ADD);
      end
      S_MEMRD: begin
        c.mem_read = 1'b1;
        c.iord     = 1'b1;
      end
      S_MEMWB: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        c.mem_write = 1'b1;
        c.iord      = 1'b1;
      end
      S_EXEC, S_MDU: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = (opc == OP_RTYPE) ? 2'b00 : 2'b10;
        c.alu_op    = exec_aluop(opc);
        c.mdu_start = (s == S_EXEC) && ((opc == OP_IMUL) || (opc == OP_DIVI));
      end
      S_ALUWB: begin
        c.reg_write = 1'b1;
        c.reg_dst   = (opc == OP_RTYPE) || (opc == OP_IMUL) ||
                      (opc == OP_DIVI)  || (opc == OP_ALU18);
      end
      S_BRANCH: begin
        c.alu_src_a     = 1'b1;
        c.pc_write_cond = 1'b1;
        c.pc_source     = 2'b01;
        c.alu_op        = (opc == OP_BR6) ? ALUOP_W'(1) : ALUOP_W'(opc);
      end
      S_JUMP: begin
        c.pc_write  = 1'b1;
        c.pc_source = 2'b10;
        c.alu_op    = ALUOP_W'(14);
      end
      S_JAL: begin
        c.pc_write  = 1'b1;
        c.pc_source = 2'b10;
        c.reg_write = 1'b1;
        c.link_sel  = 1'b1;
        c.alu_op    = ALUOP_W'(16);
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE:   state_d = S_FETCH;
      S_FETCH:  if (mem_ok) state_d = S_DECODE;
      S_DECODE: state_d = decode_target(opcode);
      S_MEMADR: state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  if (mem_ok) state_d = S_MEMWB;
      S_MEMWB:  state_d = S_FETCH;
      S_MEMWR:  if (mem_ok) state_d = S_FETCH;
      S_EXEC: begin
        if (is_mdu && (MDU_LAT > 0)) begin
          state_d = S_MDU;
          cnt_d   = CNT_W'(MDU_LAT - 1);
        end else begin
          state_d = S_ALUWB;
        end
      end
      // Counter is preloaded with MDU_LAT-1 so the dwell is exactly MDU_LAT cycles.
      S_MDU: begin
        if (cnt_q == '0) state_d = S_ALUWB;
        else             cnt_d   = cnt_q - 1'b1;
      end
      S_ALUWB, S_BRANCH, S_JUMP, S_JAL: state_d = S_FETCH;
      S_TRAP:   state_d = S_TRAP;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      ctrl_q    <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ctrl_q  <= decode_ctrl(state_d, opcode);
      if (state_d == S_TRAP) illegal_q <= 1'b1;
    end
  end

  // IR load and PC increment in FETCH follow the live memory handshake.
  assign fetch_adv   = (state_q == S_FETCH) && mem_ok;

  assign PCWrite     = ctrl_q.pc_write | fetch_adv;
  assign IRWrite     = fetch_adv;
  assign PCWriteCond = ctrl_q.pc_write_cond;
  assign IorD        = ctrl_q.iord;
  assign MemRead     = ctrl_q.mem_read;
  assign MemWrite    = ctrl_q.mem_write;
  assign MemtoReg    = ctrl_q.mem_to_reg;
  assign RegDst      = ctrl_q.reg_dst;
  assign RegWrite    = ctrl_q.reg_write;
  assign ALUSrcA     = ctrl_q.alu_src_a;
  assign LinkSel     = ctrl_q.link_sel;
  assign mdu_start   = ctrl_q.mdu_start;
  assign ALUSrcB     = ctrl_q.alu_src_b;
  assign PCSource    = ctrl_q.pc_source;
  assign ALUOp       = ctrl_q.alu_op;
  assign illegal_op  = illegal_q;
  assign state       = state_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Bench for multicycle_control_fsm: per-instruction phase model drives mem_ready and predicts every output each cycle.
module tb_multicycle_control_fsm;

  logic       clk = 1'b0;
  logic       reset_v     [2];
  logic [5:0] opcode_v    [2];
  logic       mem_ready_v [2];

  logic       pcw [2], pcwc [2], iord [2], mrd [2], mwr [2], irw [2];
  logic       m2r [2], rdst [2], rw [2], srca [2], link [2], mdus [2], ill [2];
  logic [1:0] srcb [2], pcs [2];
  logic [5:0] aop [2];
  logic [3:0] st [2];
  logic [26:0] obs [2];

  int checks = 0;
  int errors = 0;

  typedef struct { int st; bit mr; } step_t;
  step_t q[$];

  always #5 clk = ~clk;

  multicycle_control_fsm #(.MDU_LAT(4)) dut (
    .clk(clk), .reset(reset_v[0]), .opcode(opcode_v[0]), .mem_ready(mem_ready_v[0]),
    .PCWrite(pcw[0]), .PCWriteCond(pcwc[0]), .IorD(iord[0]), .MemRead(mrd[0]),
    .MemWrite(mwr[0]), .IRWrite(irw[0]), .MemtoReg(m2r[0]), .RegDst(rdst[0]),
    .RegWrite(rw[0]), .ALUSrcA(srca[0]), .LinkSel(link[0]), .mdu_start(mdus[0]),
    .ALUSrcB(srcb[0]), .PCSource(pcs[0]), .ALUOp(aop[0]), .illegal_op(ill[0]), .state(st[0])
  );

  multicycle_control_fsm #(.MDU_LAT(0)) dut_nolat (
    .clk(clk), .reset(reset_v[1]), .opcode(opcode_v[1]), .mem_ready(mem_ready_v[1]),
    .PCWrite(pcw[1]), .PCWriteCond(pcwc[1]), .IorD(iord[1]), .MemRead(mrd[1]),
    .MemWrite(mwr[1]), .IRWrite(irw[1]), .MemtoReg(m2r[1]), .RegDst(rdst[1]),
    .RegWrite(rw[1]), .ALUSrcA(srca[1]), .LinkSel(link[1]), .mdu_start(mdus[1]),
    .ALUSrcB(srcb[1]), .PCSource(pcs[1]), .ALUOp(aop[1]), .illegal_op(ill[1]), .state(st[1])
  );

  assign obs[0] = {pcw[0], pcwc[0], iord[0], mrd[0], mwr[0], irw[0], m2r[0], rdst[0], rw[0],
                   srca[0], link[0], mdus[0], srcb[0], pcs[0], aop[0], ill[0], st[0]};
  assign obs[1] = {pcw[1], pcwc[1], iord[1], mrd[1], mwr[1], irw[1], m2r[1], rdst[1], rw[1],
                   srca[1], link[1], mdus[1], srcb[1], pcs[1], aop[1], ill[1], st[1]};

  // Instruction class: 0 alu, 1 mul/div, 2 load, 3 store, 4 branch, 5 jump, 6 jal, 7 illegal
  function automatic int op_class(input logic [5:0] opc);
    case (opc)
      6'd0, 6'd1, 6'd7, 6'd18:                 return 0;
      6'd15, 6'd16:                            return 1;
      6'd4:                                    return 2;
      6'd5:                                    return 3;
      6'd6, 6'd8, 6'd9, 6'd10, 6'd11, 6'd12, 6'd13: return 4;
      6'd14:                                   return 5;
      6'd17:                                   return 6;
      default:                                 return 7;
    endcase
  endfunction

  function automatic int exec_alu(input logic [5:0] opc);
    case (opc)
      6'd1, 6'd7:   return 2;
      6'd15, 6'd16: return 15;
      6'd18:        return 17;
      default:      return 0;
    endcase
  endfunction

  // Expected output word for a given state number, opcode and mem_ready.
  function automatic logic [26:0] exp_vec(input int s, input logic [5:0] opc, input bit mr);
    logic e_pcw, e_pcwc, e_iord, e_mrd, e_mwr, e_irw, e_m2r, e_rdst, e_rw, e_srca, e_link, e_mdus, e_ill;
    logic [1:0] e_srcb, e_pcs;
    int e_aop;
    {e_pcw, e_pcwc, e_iord, e_mrd, e_mwr, e_irw, e_m2r, e_rdst, e_rw, e_srca, e_link, e_mdus, e_ill} = '0;
    e_srcb = 2'b00; e_pcs = 2'b00; e_aop = 0;
    case (s)
      1:  begin e_mrd = 1; e_srcb = 2'b01; e_aop = 3; e_irw = mr; e_pcw = mr; end
      2:  begin e_srcb = 2'b11; e_aop = 3; end
      3:  begin e_srca = 1; e_srcb = 2'b10; e_aop = 3; end
      4:  begin e_mrd = 1; e_iord = 1; end
      5:  begin e_rw = 1; e_m2r = 1; end
      6:  begin e_mwr = 1; e_iord = 1; end
      7, 12: begin
        e_srca = 1;
        e_srcb = (opc == 6'd0) ? 2'b00 : 2'b10;
        e_aop  = exec_alu(opc);
        e_mdus = (s == 7) && (op_class(opc) == 1);
      end
      8:  begin e_rw = 1; e_rdst = (opc == 6'd0 || opc == 6'd15 || opc == 6'd16 || opc == 6'd18); end
      9:  begin e_srca = 1; e_pcwc = 1; e_pcs = 2'b01; e_aop = (opc == 6'd6) ? 1 : int'(opc); end
      10: begin e_pcw = 1; e_pcs = 2'b10; e_aop = 14; end
      11: begin e_pcw = 1; e_pcs = 2'b10; e_rw = 1; e_link = 1; e_aop = 16; end
      13: e_ill = 1;
      default: ;
    endcase
    return {e_pcw, e_pcwc, e_iord, e_mrd, e_mwr, e_irw, e_m2r, e_rdst, e_rw, e_srca, e_link, e_mdus,
            e_srcb, e_pcs, 6'(e_aop), e_ill, 4'(s)};
  endfunction

  function automatic bit rnd_bit();
    return bit'($urandom_range(0, 1));
  endfunction

  // Phase list of one instruction from its first FETCH cycle up to (not including) the next FETCH.
  task automatic build(input logic [5:0] opc, input int wf, input int wm, input int lat);
    q.delete();
    repeat (wf) q.push_back('{1, 1'b0});
    q.push_back('{1, 1'b1});
    q.push_back('{2, rnd_bit()});
    case (op_class(opc))
      0: begin q.push_back('{7, rnd_bit()}); q.push_back('{8, rnd_bit()}); end
      1: begin
        q.push_back('{7, rnd_bit()});
        repeat (lat) q.push_back('{12, rnd_bit()});
        q.push_back('{8, rnd_bit()});
      end
      2: begin
        q.push_back('{3, rnd_bit()});
        repeat (wm) q.push_back('{4, 1'b0});
        q.push_back('{4, 1'b1});
        q.push_back('{5, rnd_bit()});
      end
      3: begin
        q.push_back('{3, rnd_bit()});
        repeat (wm) q.push_back('{6, 1'b0});
        q.push_back('{6, 1'b1});
      end
      4: q.push_back('{9, rnd_bit()});
      5: q.push_back('{10, rnd_bit()});
      6: q.push_back('{11, rnd_bit()});
      default: repeat (20) q.push_back('{13, rnd_bit()});
    endcase
  endtask

  task automatic check(input int sel, input string tag, input int idx, input logic [26:0] exp);
    checks++;
    assert (obs[sel] === exp) else begin
      errors++;
      $error("FAIL %s dut%0d step%0d: got %h expected %h", tag, sel, idx, obs[sel], exp);
    end
  endtask

  // Called at posedge+1 of the instruction's first FETCH cycle; returns at posedge+1 of the next cycle.
  // cut >= 0 asserts reset during that step and stops there.
  task automatic run_instr(input int sel, input logic [5:0] opc, input int wf, input int wm,
                           input int cut, input string tag);
    build(opc, wf, wm, (sel == 0) ? 4 : 0);
    opcode_v[sel] = opc;
    for (int i = 0; i < q.size(); i++) begin
      mem_ready_v[sel] = q[i].mr;
      #1;
      check(sel, tag, i, exp_vec(q[i].st, opc, q[i].mr));
      if (i == cut) reset_v[sel] = 1'b1;
      @(posedge clk); #1;
      if (i == cut) break;
    end
  endtask

  logic [5:0] legal_ops [19];

  initial begin
    legal_ops = '{6'd0, 6'd1, 6'd7, 6'd15, 6'd16, 6'd18, 6'd4, 6'd5, 6'd6, 6'd8,
                  6'd9, 6'd10, 6'd11, 6'd12, 6'd13, 6'd14, 6'd17, 6'd4, 6'd5};
    reset_v     = '{1'b1, 1'b1};
    mem_ready_v = '{1'b1, 1'b1};
    opcode_v    = '{6'd0, 6'd0};

    repeat (3) begin
      @(posedge clk); #1;
      check(0, "reset_hold", 0, 27'd0);
    end
    reset_v[0] = 1'b0;
    @(posedge clk); #1;

    run_instr(0, 6'd0, 0, 0, -1, "rtype");
    run_instr(0, 6'd4, 0, 2, -1, "lw_wait");
    run_instr(0, 6'd5, 1, 1, -1, "sw_wait");
    run_instr(0, 6'd15, 0, 0, -1, "imul_lat4");
    for (int op = 8; op <= 13; op++) run_instr(0, 6'(op), 0, 0, -1, "branch");
    run_instr(0, 6'd17, 0, 0, -1, "jal");

    for (int n = 0; n < 40; n++) begin
      int k;
      k = $urandom_range(0, 18);
      run_instr(0, legal_ops[k], $urandom_range(0, 2), $urandom_range(0, 2), -1, "random");
    end

    // Reset while the MDU counter reads 2 (second MDU cycle, step 4).
    run_instr(0, 6'd15, 0, 0, 4, "mdu_reset");
    check(0, "mdu_reset_idle", 0, 27'd0);
    reset_v[0] = 1'b0;
    @(posedge clk); #1;
    run_instr(0, 6'd15, 0, 0, -1, "imul_after_reset");

    run_instr(0, 6'h3f, 0, 0, -1, "trap");
    reset_v[0] = 1'b1;
    @(posedge clk); #1;
    check(0, "trap_reset", 0, 27'd0);
    reset_v[0] = 1'b0;
    @(posedge clk); #1;
    run_instr(0, 6'd0, 0, 0, -1, "post_trap");

    reset_v[1] = 1'b0;
    check(1, "nolat_idle", 0, 27'd0);
    @(posedge clk); #1;
    run_instr(1, 6'd15, 0, 0, -1, "imul_lat0");
    run_instr(1, 6'd16, 1, 0, -1, "divi_lat0");
    run_instr(1, 6'd19, 0, 0, -1, "trap_nolat");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
